if_fetch_unit: RTL and testbench

- Instruction fetch stage of the five-stage pipeline. Issues in-order requests to instruction memory and buffers returned words with their PCs.
- Presents a valid/ready instruction stream to IF/ID, which feeds the opcode decoder.
- Consumes the decoder's flush/redirect (branch taken, jump): discards all buffered and in-flight fetches and restarts at the target PC.

---
 rtl/if_fetch_unit_pkg.sv | 16 +
 rtl/if_fetch_fifo.sv | 59 +++++
 rtl/if_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: word width, NOP encoding, reset PC and FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_fetch_unit_pkg;

  localparam int          IF_XLEN     = 32;
  localparam logic [31:0] IF_NOP      = 32'h0000_0013;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_BOOT = 2'd0,
    IF_RUN  = 2'd1,
    IF_HALT = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_fetch_fifo.sv
// Fetch queue: FIFO of {pc, instr} entries between memory responses and IF/ID.
// Latency: a push is visible at the head on the next cycle (head read directly from storage).
// Backpressure: the caller never pushes into a full queue unless it pops in the same cycle; flush beats push/pop.
module if_fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  // Entry storage; head is qualified by the count, so no reset is needed here
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointers and occupancy; a flush empties the queue regardless of push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_valid = (count_q != '0);
  assign head_data  = mem[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: in-order imem requests, response queue, valid/ready stream to IF/ID (optional IF_MISALIGN_TRAP_EN).
// Latency: first request one cycle after BOOT or a redirect; a response at cycle t is presented at t+1 when the queue is empty.
// Backpressure: id_ready low holds the head; issue stops once queued plus live in-flight fetches reach FQ_DEPTH.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = IF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = IF_RESET_PC,
  parameter int              FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            id_ready,
  output logic            if_misalign
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  // In-flight and discard counts can exceed FQ_DEPTH: stale fetches still
  // draining after a redirect sit alongside a fresh issue budget.
  localparam int OW = CW + 1;
  localparam int BW = OW + 1;
`ifdef IF_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, resp_pc_q, target_pc;
  logic [OW-1:0]   outst_q, outst_d, discard_q;
  logic [CW-1:0]   occ;
  logic [BW-1:0]   budget;
  logic            redir, redir_bad, can_issue;
  logic            hs, rsp, rsp_drop, push, pop, head_vld;
  fq_entry_t       push_entry, head_entry;

  assign redir      = redirect_valid && (state_q != IF_BOOT);
  assign redir_bad  = TRAP_EN && redir && (redirect_pc[1:0] != 2'b00);
  assign target_pc  = {redirect_pc[XLEN-1:2], 2'b00};
  assign budget     = BW'(occ) + BW'(outst_q) - BW'(discard_q);
  assign can_issue  = (budget < BW'(FQ_DEPTH)) && (outst_q != {OW{1'b1}}) && !redirect_valid;

  assign hs         = imem_req && imem_ready;
  assign rsp        = imem_rvalid && (outst_q != '0);
  assign rsp_drop   = rsp && (discard_q != '0);
  assign push       = rsp && !rsp_drop && !redir;
  assign pop        = head_vld && id_ready && !redir;
  assign outst_d    = outst_q + OW'(hs) - OW'(rsp);
  assign push_entry = '{pc: resp_pc_q, instr: imem_rdata};
  assign imem_addr  = fetch_pc_q;

  // Next state and request enable; nothing is issued in BOOT or HALT
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      IF_BOOT: state_d = IF_RUN;
      IF_RUN: begin
        imem_req = can_issue;
        if (redir_bad) state_d = IF_HALT;
      end
      IF_HALT: if (redir && !redir_bad) state_d = IF_RUN;
      default: state_d = IF_BOOT;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IF_BOOT;
    else        state_q <= state_d;
  end

  // Fetch/response PCs and counters; a redirect turns every in-flight fetch into a discard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      outst_q <= outst_d;
      if (redir) begin
        fetch_pc_q <= target_pc;
        resp_pc_q  <= target_pc;
        discard_q  <= outst_d;
      end else begin
        if (hs)       fetch_pc_q <= fetch_pc_q + XLEN'(4);
        if (push)     resp_pc_q  <= resp_pc_q + XLEN'(4);
        if (rsp_drop) discard_q  <= discard_q - OW'(1);
      end
    end
  end

  if_fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .flush      (redir),
    .head_valid (head_vld),
    .head_data  (head_entry),
    .count      (occ)
  );

  assign if_valid = head_vld;
  assign if_instr = head_vld ? head_entry.instr : XLEN'(IF_NOP);

`ifdef IF_MISALIGN_TRAP_EN
  logic [XLEN-1:0] halt_pc_q;

  // Keep the offending target visible on if_pc while halted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         halt_pc_q <= '0;
    else if (redir_bad) halt_pc_q <= redirect_pc;
  end

  assign if_misalign = (state_q == IF_HALT);
  assign if_pc       = (state_q == IF_HALT) ? halt_pc_q : (head_vld ? head_entry.pc : '0);
`else
  assign if_misalign = 1'b0;
  assign if_pc       = head_vld ? head_entry.pc : '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: cycle table of inputs/expected request and head state, plus an instruction scoreboard.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: exercised through id_ready stalls and imem_ready holds in the table.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;
  logic        if_misalign;

  if_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .id_ready       (id_ready),
    .if_misalign    (if_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, idr, rv;
    logic [31:0] rdata;
    logic        acc;
    logic [31:0] acc_pc;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  vec_t        tbl[$];
  logic [63:0] sb[$];

  function automatic vec_t mk(input logic rdy, input logic idr, input logic rv, input logic [31:0] rdata,
                              input logic acc, input logic [31:0] acc_pc, input logic redir, input logic [31:0] rpc,
                              input logic e_req, input logic [31:0] e_addr, input logic e_vld, input logic [31:0] e_pc,
                              input logic e_mis);
    vec_t v;
    v.rdy = rdy; v.idr = idr; v.rv = rv; v.rdata = rdata; v.acc = acc; v.acc_pc = acc_pc;
    v.redir = redir; v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
    v.e_pc = e_pc; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"},   32'(imem_req),    32'd0);
    chk({tag, "_addr"},  imem_addr,        32'h0);
    chk({tag, "_vld"},   32'(if_valid),    32'd0);
    chk({tag, "_pc"},    if_pc,            32'h0);
    chk({tag, "_instr"}, if_instr,         32'h0000_0013);
    chk({tag, "_mis"},   32'(if_misalign), 32'd0);
  endtask

  // One cycle: drive, sample on the falling edge, compare against the row and the scoreboard
  task automatic apply(input vec_t v, input string tag);
    logic [63:0] e;
    @(posedge clk);
    #1;
    imem_ready     = v.rdy;
    imem_rvalid    = v.rv;
    imem_rdata     = v.rdata;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    id_ready       = v.idr;
    if (v.acc) sb.push_back({v.acc_pc, v.rdata});
    @(negedge clk);
    chk({tag, "_req"}, 32'(imem_req), 32'(v.e_req));
    if (v.e_req) chk({tag, "_addr"}, imem_addr, v.e_addr);
    chk({tag, "_vld"}, 32'(if_valid), 32'(v.e_vld));
    if (v.e_vld || v.e_mis) chk({tag, "_pc"}, if_pc, v.e_pc);
    chk({tag, "_mis"}, 32'(if_misalign), 32'(v.e_mis));
    if (if_valid && id_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s_sb: got pop pc=%h with no instruction expected", tag, if_pc);
      end else begin
        e = sb.pop_front();
        chk({tag, "_sb_pc"},    if_pc,    e[63:32]);
        chk({tag, "_sb_instr"}, if_instr, e[31:0]);
      end
    end
    if (v.redir) sb.delete();
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;

    //             rdy idr rv rdata          acc acc_pc  rdr rpc      req addr     vld pc      mis
    tbl.push_back(mk(1, 1, 0, 0,             0, 0,       0, 0,        1, 'h0,      0, 0,       0));
    tbl.push_back(mk(1, 1, 0, 0,             0, 0,       0, 0,        1, 'h4,      0, 0,       0));
    tbl.push_back(mk(1, 1, 0, 0,             0, 0,       0, 0,        1, 'h8,      0, 0,       0));
    tbl.push_back(mk(1, 1, 0, 0,             0, 0,       0, 0,        1, 'hC,      0, 0,       0));
    tbl.push_back(mk(1, 1, 1, 'h0000_0093,   1, 'h0,     0, 0,        0, 0,        0, 0,       0));
    tbl.push_back(mk(1, 1, 1, 'h0010_0113,   1, 'h4,     0, 0,        0, 0,        1, 'h0,     0));
    tbl.push_back(mk(1, 1, 0, 0,             0, 0,       0, 0,        1, 'h10,     1, 'h4,     0));
    tbl.push_back(mk(0, 1, 0, 0,             0, 0,       0, 0,        1, 'h14,     0, 0,       0));
    tbl.push_back(mk(1, 1, 0, 0,             0, 0,       0, 0,        1, 'h14,     0, 0,       0));
    tbl.push_back(mk(1, 0, 1, 'h1111_1111,   1, 'h8,     0, 0,        0, 0,        0, 0,       0));
    tbl.push_back(mk(1, 0, 1, 'h2222_2222,   1, 'hC,     0, 0,        0, 0,        1, 'h8,     0));
    tbl.push_back(mk(1, 0, 1, 'h3333_3333,   1, 'h10,    0, 0,        0, 0,        1, 'h8,     0));
    tbl.push_back(mk(1, 0, 1, 'h4444_4444,   1, 'h14,    0, 0,        0, 0,        1, 'h8,     0));
    tbl.push_back(mk(1, 0, 0, 0,             0, 0,       0, 0,        0, 0,        1, 'h8,     0));
    tbl.push_back(mk(1, 0, 0, 0,             0, 0,       0, 0,        0, 0,        1, 'h8,     0));
    tbl.push_back(mk(1, 1, 0, 0,             0, 0,       0, 0,        0, 0,        1, 'h8,     0));
    tbl.push_back(mk(1, 1, 0, 0,             0, 0,       0, 0,        1, 'h18,     1, 'hC,     0));
    tbl.push_back(mk(1, 1, 0, 0,             0, 0,       0, 0,        1, 'h1C,     1, 'h10,    0));
    tbl.push_back(mk(1, 1, 0, 0,             0, 0,       0, 0,        1, 'h20,     1, 'h14,    0));
    tbl.push_back(mk(1, 1, 0, 0,             0, 0,       0, 0,        1, 'h24,     0, 0,       0));
    tbl.push_back(mk(1, 0, 1, 'h5555_5555,   1, 'h18,    0, 0,        0, 0,        0, 0,       0));
    tbl.push_back(mk(1, 0, 0, 0,             0, 0,       1, 'h100,    0, 0,        1, 'h18,    0));
    tbl.push_back(mk(1, 1, 1, 'hDEAD_0001,   0, 0,       0, 0,        1, 'h100,    0, 0,       0));
    tbl.push_back(mk(1, 1, 1, 'hDEAD_0002,   0, 0,       0, 0,        1, 'h104,    0, 0,       0));
    tbl.push_back(mk(1, 1, 1, 'hDEAD_0003,   0, 0,       0, 0,        1, 'h108,    0, 0,       0));
    tbl.push_back(mk(1, 1, 1, 'h6666_6666,   1, 'h100,   0, 0,        1, 'h10C,    0, 0,       0));
    tbl.push_back(mk(0, 1, 0, 0,             0, 0,       0, 0,        0, 0,        1, 'h100,   0));
    tbl.push_back(mk(0, 1, 0, 0,             0, 0,       0, 0,        1, 'h110,    0, 0,       0));
    tbl.push_back(mk(0, 1, 1, 'h7777_7777,   1, 'h104,   0, 0,        1, 'h110,    0, 0,       0));
    tbl.push_back(mk(1, 1, 1, 'hDEAD_0004,   0, 0,       1, 'h200,    0, 0,        1, 'h104,   0));
    tbl.push_back(mk(1, 1, 0, 0,             0, 0,       0, 0,        1, 'h200,    0, 0,       0));
    tbl.push_back(mk(0, 1, 1, 'hDEAD_0005,   0, 0,       0, 0,        1, 'h204,    0, 0,       0));
    tbl.push_back(mk(0, 1, 1, 'h8888_8888,   1, 'h200,   0, 0,        1, 'h204,    0, 0,       0));
    tbl.push_back(mk(0, 1, 0, 0,             0, 0,       0, 0,        1, 'h204,    1, 'h200,   0));
    tbl.push_back(mk(0, 1, 0, 0,             0, 0,       1, 'h102,    0, 0,        0, 0,       0));
`ifdef IF_MISALIGN_TRAP_EN
    tbl.push_back(mk(0, 1, 0, 0,             0, 0,       0, 0,        0, 0,        0, 'h102,   1));
    tbl.push_back(mk(0, 1, 0, 0,             0, 0,       1, 'h200,    0, 0,        0, 'h102,   1));
`else
    tbl.push_back(mk(0, 1, 0, 0,             0, 0,       0, 0,        1, 'h100,    0, 0,       0));
    tbl.push_back(mk(0, 1, 0, 0,             0, 0,       1, 'h200,    0, 0,        0, 0,       0));
`endif
    tbl.push_back(mk(1, 1, 0, 0,             0, 0,       0, 0,        1, 'h200,    0, 0,       0));

    // Power-on reset values, then one BOOT cycle with no request
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    imem_ready = 1'b1;
    id_ready = 1'b1;
    #1;
    chk("por_boot_req", 32'(imem_req), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("r%0d", i));
    end

    // Mid-operation reset with a stray response; it must be ignored after release
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_0000;
    imem_ready = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    sb.delete();
    #1;
    check_reset("mid");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_boot_req", 32'(imem_req), 32'd0);
    apply(mk(0, 1, 1, 'hBAD0_0001, 0, 0, 0, 0, 1, 'h0, 0, 0, 0), "m0");
    apply(mk(1, 1, 0, 0,           0, 0, 0, 0, 1, 'h0, 0, 0, 0), "m1");
    apply(mk(0, 1, 1, 'h0050_0293, 1, 'h0, 0, 0, 1, 'h4, 0, 0, 0), "m2");
    apply(mk(0, 1, 0, 0,           0, 0, 0, 0, 1, 'h4, 1, 'h0, 0), "m3");

    chk("sb_leftover", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
